mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/riscv_pkg.sv | 14 +
 rtl/mem_bridge.sv | 128 ++++++++++++
 tb/tb_mem_bridge.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the CPU data-side memory bridge.
//   bridge_state_t  : bridge FSM state encoding (IDLE -> REQ -> DONE -> IDLE)
//   BRIDGE_TIMEOUT  : default maximum number of bus wait cycles before abort
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  localparam int unsigned BRIDGE_TIMEOUT = 255;

endpackage

// File: rtl/mem_bridge.sv
// CPU data-access to single-master bus bridge.
// Converts a CPU load/store request into one bus cycle, stalls the CPU until
// the cycle completes, returns load data and records bus errors/timeouts.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cpu_addr/cpu_din/cpu_w    store/load address, store data, byte write enables
//   cpu_r                     load request
//   cpu_dout                  last load data (0 after a faulting access)
//   cpu_stall                 hold CPU while an access is outstanding
//   bus_cyc/bus_we/bus_sel    bus request, write flag, byte lane selects
//   bus_addr/bus_wdata        word-aligned address, write data
//   bus_rdata/bus_ack/bus_err read data, completion OK, completion with error
//   fault/fault_addr          sticky fault flag, address of first faulting access
//   fault_clr                 synchronous fault clear
module mem_bridge
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = BRIDGE_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [XLEN-1:0]   cpu_addr,
  input  logic [XLEN-1:0]   cpu_din,
  input  logic [XLEN/8-1:0] cpu_w,
  input  logic              cpu_r,
  output logic [XLEN-1:0]   cpu_dout,
  output logic              cpu_stall,
  output logic              bus_cyc,
  output logic              bus_we,
  output logic [XLEN/8-1:0] bus_sel,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  output logic              fault,
  output logic [XLEN-1:0]   fault_addr,
  input  logic              fault_clr
);

  // Counter holds the number of completed REQ cycles, so the abort fires on
  // the TIMEOUT-th REQ cycle when it reads TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  bridge_state_t     state;
  logic [7:0]        cnt;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN/8-1:0] sel_q;
  logic              we_q;

  logic req_in;
  logic abort;

  always_comb begin
    req_in = cpu_r | (|cpu_w);
    // bus_ack in the timeout cycle still completes normally.
    abort  = bus_err | (~bus_ack & (cnt == TO_LAST));
  end

  // Stall rises in the same cycle as the request so the CPU never advances
  // past an access that the bridge has just accepted.
  always_comb begin
    cpu_stall = 1'b0;
    if (rstn) begin
      unique case (state)
        IDLE:    cpu_stall = req_in;
        REQ:     cpu_stall = 1'b1;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    bus_cyc   = (state == REQ);
    bus_we    = we_q;
    bus_sel   = sel_q;
    bus_addr  = {addr_q[XLEN-1:2], 2'b00};
    bus_wdata = data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cpu_dout   <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      if (fault_clr) fault <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req_in) begin
            addr_q <= cpu_addr;
            data_q <= cpu_din;
            we_q   <= |cpu_w;
            sel_q  <= (|cpu_w) ? cpu_w : '1;
            cnt    <= '0;
            state  <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (abort) begin
            // A new fault overrides a same-cycle clear and counts as the first.
            fault <= 1'b1;
            if (!fault || fault_clr) fault_addr <= addr_q;
            cpu_dout <= '0;
            state    <= DONE;
          end else if (bus_ack) begin
            if (!we_q) cpu_dout <= bus_rdata;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge (XLEN=32, TIMEOUT=4).
module tb_mem_bridge;

  localparam int TO = 4;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_din = '0;
  logic [3:0]  cpu_w = '0;
  logic        cpu_r = 1'b0;
  logic [31:0] cpu_dout;
  logic        cpu_stall;
  logic        bus_cyc;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic        fault;
  logic [31:0] fault_addr;
  logic        fault_clr = 1'b0;

  mem_bridge #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_w(cpu_w), .cpu_r(cpu_r),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic        fault;
    logic [31:0] faddr;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference state of the CPU-visible results.
  logic [31:0] m_dout = '0;
  logic        m_fault = 1'b0;
  logic [31:0] m_faddr = '0;

  // One complete access. wait_cyc = REQ cycles without response before the
  // response cycle; kind selects ack, err or no response (timeout).
  task automatic run_access(input string name, input logic rd, input logic [3:0] wr,
                            input logic [31:0] addr, input logic [31:0] din,
                            input int wait_cyc, input int kind,
                            input logic [31:0] rdata, input logic clr_on_resp);
    exp_t e;
    exp_t got;
    int   n;
    logic timed_out;
    logic fail;
    timed_out = (kind == K_NONE) || (wait_cyc >= TO);
    fail      = timed_out || (kind == K_ERR);
    e.we     = |wr;
    e.sel    = (|wr) ? wr : 4'hF;
    e.addr   = {addr[31:2], 2'b00};
    e.wdata  = din;
    e.cycles = timed_out ? TO : wait_cyc + 1;
    if (fail) begin
      if (!m_fault || clr_on_resp) m_faddr = addr;
      m_fault = 1'b1;
      m_dout  = '0;
    end else if (!e.we) begin
      m_dout = rdata;
    end
    e.dout  = m_dout;
    e.fault = m_fault;
    e.faddr = m_faddr;
    sb.push_back(e);

    @(negedge clk);
    cpu_r = rd; cpu_w = wr; cpu_addr = addr; cpu_din = din;
    #1;
    checks++;
    if (cpu_stall !== 1'b1 || bus_cyc !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_stall: stall=%b cyc=%b, expected stall=1 cyc=0", name, cpu_stall, bus_cyc);
    end

    @(negedge clk);
    got = sb.pop_front();
    checks++;
    if ({bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata} !==
        {1'b1, got.we, got.sel, got.addr, got.wdata}) begin
      errors++;
      $display("FAIL %s bus_req: cyc=%b we=%b sel=%h addr=%h wdata=%h, expected cyc=1 we=%b sel=%h addr=%h wdata=%h",
               name, bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata, got.we, got.sel, got.addr, got.wdata);
    end
    // Request inputs change while the access is outstanding; bridge must ignore them.
    cpu_addr = ~addr; cpu_din = ~din; cpu_w = ~wr;

    n = 0;
    while (bus_cyc === 1'b1 && n < 64) begin
      if (n == wait_cyc && kind != K_NONE) begin
        bus_ack   = (kind == K_ACK);
        bus_err   = (kind == K_ERR);
        bus_rdata = rdata;
        fault_clr = clr_on_resp;
      end else begin
        bus_rdata = 32'hBAD0_0000 | 32'(n);
      end
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0; fault_clr = 1'b0;
      n++;
    end
    cpu_r = 1'b0; cpu_w = '0;

    checks++;
    if (n !== got.cycles) begin
      errors++;
      $display("FAIL %s req_cycles: got %0d, expected %0d", name, n, got.cycles);
    end
    checks++;
    if ({bus_cyc, cpu_stall} !== 2'b00) begin
      errors++;
      $display("FAIL %s done_release: cyc=%b stall=%b, expected 0 0", name, bus_cyc, cpu_stall);
    end
    checks++;
    if ({cpu_dout, fault, fault_addr} !== {got.dout, got.fault, got.faddr}) begin
      errors++;
      $display("FAIL %s completion: dout=%h fault=%b faddr=%h, expected dout=%h fault=%b faddr=%h",
               name, cpu_dout, fault, fault_addr, got.dout, got.fault, got.faddr);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cpu_r = 1'b1;
    #13;
    checks++;
    if ({cpu_stall, bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata, cpu_dout, fault, fault_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state: stall=%b cyc=%b we=%b sel=%h addr=%h wdata=%h dout=%h fault=%b faddr=%h, expected all 0",
               cpu_stall, bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata, cpu_dout, fault, fault_addr);
    end
    cpu_r = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_read();
    run_access("read_104", 1'b1, 4'b0000, 32'h104, 32'h0, 2, K_ACK, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_write();
    run_access("store_203", 1'b0, 4'b0011, 32'h203, 32'h1234, 0, K_ACK, 32'h5555_AAAA, 1'b0);
    run_access("write_wins", 1'b1, 4'b1100, 32'h012, 32'hA5A5_0000, 1, K_ACK, 32'h7777_7777, 1'b0);
  endtask

  task automatic test_fault_clr(input string name);
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    m_fault = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_addr !== m_faddr) begin
      errors++;
      $display("FAIL %s: fault=%b faddr=%h, expected fault=0 faddr=%h", name, fault, fault_addr, m_faddr);
    end
  endtask

  task automatic test_bus_error();
    run_access("err_first", 1'b1, 4'b0000, 32'h302, 32'h0, 1, K_ERR, 32'h1111_1111, 1'b0);
    run_access("err_second", 1'b1, 4'b0000, 32'h404, 32'h0, 0, K_ERR, 32'h2222_2222, 1'b0);
    run_access("err_with_clr", 1'b1, 4'b0000, 32'h508, 32'h0, 0, K_ERR, 32'h3333_3333, 1'b1);
    test_fault_clr("fault_clr_1");
  endtask

  task automatic test_timeout();
    run_access("timeout", 1'b1, 4'b0000, 32'h700, 32'h0, 0, K_NONE, 32'h0, 1'b0);
    test_fault_clr("fault_clr_2");
    run_access("ack_last_cycle", 1'b1, 4'b0000, 32'h704, 32'h0, TO - 1, K_ACK, 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_access("b2b_load", 1'b1, 4'b0000, 32'h800 + 32'(4 * i), 32'h0, i % 2, K_ACK, $urandom, 1'b0);
    end
  endtask

  task automatic test_reset_mid_req();
    int hits;
    @(negedge clk);
    cpu_r = 1'b1; cpu_addr = 32'h900;
    @(negedge clk);
    checks++;
    if (bus_cyc !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req_enter: cyc=%b, expected 1", bus_cyc);
    end
    #2 rstn = 1'b0;
    cpu_r = 1'b0;
    #1;
    m_dout = '0; m_fault = 1'b0; m_faddr = '0;
    checks++;
    if ({bus_cyc, cpu_stall, cpu_dout, fault, fault_addr} !== '0) begin
      errors++;
      $display("FAIL rst_mid_req_async: cyc=%b stall=%b dout=%h fault=%b faddr=%h, expected all 0",
               bus_cyc, cpu_stall, cpu_dout, fault, fault_addr);
    end
    @(negedge clk);
    rstn = 1'b1;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      bus_ack = 1'b1; bus_rdata = 32'hFEED_0000;
      @(negedge clk);
      if (bus_cyc !== 1'b0 || cpu_stall !== 1'b0 || cpu_dout !== 32'h0) hits++;
    end
    bus_ack = 1'b0;
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL rst_mid_req_after: %0d cycles showed activity, expected 0", hits);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_bus_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
